// File: rtl/ultrasonic_echo_sim.sv
// rtl/ultrasonic_echo_sim.sv - HC-SR04 sensor model: answers a trigger pulse with a distance-coded echo pulse
// Optional build macro: ULTRASONIC_JITTER_EN adds 0..63 cycles of LFSR noise to every echo width.

module ultrasonic_echo_sim #(
    parameter int TICKS_PER_CM  = 2900,
    parameter int MIN_TRIG      = 500,
    parameter int ECHO_DELAY    = 10000,
    parameter int MAX_CM        = 400,
    parameter int TIMEOUT_TICKS = 1900000,
    parameter int HOLDOFF       = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic [8:0] distance_cm,
    input  logic       enable,
    output logic       echo,
    output logic       busy,
    output logic       short_trig
);

    // One counter serves every timed state; 22 bits covers the timeout width plus jitter.
    localparam int CW = 22;

    localparam logic [CW-1:0] K_TPC      = CW'(TICKS_PER_CM);
    localparam logic [CW-1:0] K_MIN      = CW'(MIN_TRIG);
    localparam logic [CW-1:0] K_DLY_LAST = CW'(ECHO_DELAY - 1);
    localparam logic [CW-1:0] K_TIMEOUT  = CW'(TIMEOUT_TICKS);
    localparam logic [CW-1:0] K_HO_LAST  = CW'(HOLDOFF - 1);
    localparam logic [8:0]    K_MAX_CM   = 9'(MAX_CM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG_HI,
        S_BURST,
        S_ECHO,
        S_HOLDOFF
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   width;
    logic [CW-1:0]   width_base;
    logic [CW-1:0]   width_calc;

    logic            trig_m;
    logic            trig_s;
    logic            trig_d;
    logic            trig_rise;
    logic            trig_fall;
    logic            accept;

    // Two-flop synchronizer on the asynchronous trigger plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
        end else begin
            trig_m <= trigger;
            trig_s <= trig_m;
            trig_d <= trig_s;
        end
    end

    assign trig_rise = trig_s & ~trig_d;
    assign trig_fall = ~trig_s & trig_d;

    // A trigger is accepted on its falling edge only if it stayed high long enough.
    assign accept = (state == S_TRIG_HI) && trig_fall && (cnt >= K_MIN);

    // Nominal echo width: out-of-range distances (0 or beyond MAX_CM) report the timeout width.
    always_comb begin
        width_base = K_TIMEOUT;
        if ((distance_cm != 9'd0) && (distance_cm <= K_MAX_CM)) begin
            width_base = CW'(distance_cm) * K_TPC;
        end
    end

`ifdef ULTRASONIC_JITTER_EN
    // Galois LFSR x^16+x^14+x^13+x^11+1, shifted right; the step taken on acceptance feeds this echo.
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;

    // Next LFSR value, used both for the register update and for this trigger's noise.
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ 16'hB400;
        end
    end

    // Advance the noise source once per accepted trigger.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= lfsr_next;
        end
    end

    // Width with 0..63 cycles of noise added, timeout included.
    always_comb begin
        width_calc = width_base + CW'(lfsr_next[5:0]);
    end
`else
    // Width without noise.
    always_comb begin
        width_calc = width_base;
    end
`endif

    // Main sequencer: qualify the trigger, wait the burst time, drive the echo, then hold off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            width      <= '0;
            echo       <= 1'b0;
            busy       <= 1'b0;
            short_trig <= 1'b0;
        end else begin
            short_trig <= 1'b0;
            case (state)
                S_IDLE: begin
                    echo <= 1'b0;
                    // A trigger already high on return to IDLE produces no rise and is ignored.
                    if (trig_rise && enable) begin
                        state <= S_TRIG_HI;
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                    end
                end

                S_TRIG_HI: begin
                    if (trig_fall) begin
                        if (cnt >= K_MIN) begin
                            width <= width_calc;
                            cnt   <= '0;
                            state <= S_BURST;
                        end else begin
                            short_trig <= 1'b1;
                            cnt        <= '0;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end else if (cnt < K_MIN) begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_BURST: begin
                    if (cnt == K_DLY_LAST) begin
                        cnt   <= '0;
                        echo  <= 1'b1;
                        state <= S_ECHO;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_ECHO: begin
                    if (cnt == (width - CW'(1))) begin
                        cnt   <= '0;
                        echo  <= 1'b0;
                        state <= S_HOLDOFF;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_HOLDOFF: begin
                    echo <= 1'b0;
                    if (cnt == K_HO_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    cnt   <= '0;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_sim.sv
// tb/tb_ultrasonic_echo_sim.sv - directed bench for ultrasonic_echo_sim with scaled-down timing

module tb_ultrasonic_echo_sim;

    localparam int TPC   = 3;
    localparam int MINT  = 8;
    localparam int DLY   = 20;
    localparam int MAXCM = 400;
    localparam int TMO   = 1500;
    localparam int HO    = 30;
    localparam int LAT   = DLY + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trigger = 1'b0;
    logic [8:0] distance_cm = 9'd0;
    logic       enable = 1'b1;
    logic       echo;
    logic       busy;
    logic       short_trig;

    int errors = 0;
    int checks = 0;
    int n_short = 0;
    int n_rise = 0;
    logic echo_prev = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1;

    ultrasonic_echo_sim #(
        .TICKS_PER_CM(TPC), .MIN_TRIG(MINT), .ECHO_DELAY(DLY),
        .MAX_CM(MAXCM), .TIMEOUT_TICKS(TMO), .HOLDOFF(HO)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .distance_cm(distance_cm),
        .enable(enable), .echo(echo), .busy(busy), .short_trig(short_trig)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            echo_prev = 1'b0;
        end else begin
            if (short_trig === 1'b1) n_short++;
            if (echo === 1'b1 && echo_prev !== 1'b1) n_rise++;
            echo_prev = echo;
        end
    end

    task automatic exp_width(input int d, output int w);
        w = (d == 0 || d > MAXCM) ? TMO : d * TPC;
`ifdef ULTRASONIC_JITTER_EN
        m_lfsr = m_lfsr[0] ? ({1'b0, m_lfsr[15:1]} ^ 16'hB400) : {1'b0, m_lfsr[15:1]};
        w = w + int'(m_lfsr[5:0]);
`endif
    endtask

    task automatic pulse(input int n);
        trigger = 1'b1;
        repeat (n) @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic measure(output int lat, output int wid, output bit busy_drop);
        busy_drop = 0;
        lat = 0;
        wid = 0;
        while (echo !== 1'b1 && lat < 5000) begin
            @(negedge clk);
            lat++;
            if (busy !== 1'b1) busy_drop = 1;
        end
        while (echo === 1'b1 && wid < 5000) begin
            @(negedge clk);
            wid++;
            if (busy !== 1'b1) busy_drop = 1;
        end
    endtask

    task automatic count_busy(output int k);
        k = 0;
        while (busy === 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo got=%b want=0", echo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (short_trig !== 1'b0) begin errors++; $display("FAIL reset_short got=%b want=0", short_trig); end
        reset = 1'b1;
        m_lfsr = 16'hACE1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, wid, w, s0, k;
        bit bd;
        s0 = n_short;
        distance_cm = 9'd10;
        exp_width(10, w);
        pulse(MINT);
        measure(lat, wid, bd);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (wid !== w) begin errors++; $display("FAIL basic_width got=%0d want=%0d", wid, w); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL basic_busy_high got=%b want=0", bd); end
        count_busy(k);
        checks++; if (k !== HO) begin errors++; $display("FAIL basic_holdoff got=%0d want=%0d", k, HO); end
        checks++; if (n_short !== s0) begin errors++; $display("FAIL basic_no_short got=%0d want=%0d", n_short, s0); end
    endtask

    task automatic test_short_trigger;
        int s0, r0;
        s0 = n_short;
        r0 = n_rise;
        distance_cm = 9'd10;
        pulse(MINT - 1);
        repeat (60) @(negedge clk);
        checks++; if (n_short !== s0 + 1) begin errors++; $display("FAIL short_pulse_count got=%0d want=%0d", n_short - s0, 1); end
        checks++; if (n_rise !== r0) begin errors++; $display("FAIL short_no_echo got=%0d want=%0d", n_rise - r0, 0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_busy got=%b want=0", busy); end
    endtask

    task automatic test_range;
        int dl[4];
        int lat, wid, w, k;
        bit bd;
        dl = '{0, 401, 400, 1};
        foreach (dl[i]) begin
            distance_cm = 9'(dl[i]);
            exp_width(dl[i], w);
            pulse(MINT + 2);
            measure(lat, wid, bd);
            checks++; if (wid !== w) begin errors++; $display("FAIL range_width d=%0d got=%0d want=%0d", dl[i], wid, w); end
            count_busy(k);
        end
    endtask

    task automatic test_enable;
        int lat, wid, w, k, r0;
        bit bd, seen;
        r0 = n_rise;
        seen = 0;
        enable = 1'b0;
        distance_cm = 9'd7;
        pulse(MINT);
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL disabled_busy got=%b want=0", seen); end
        checks++; if (n_rise !== r0) begin errors++; $display("FAIL disabled_echo got=%0d want=0", n_rise - r0); end
        enable = 1'b1;
        exp_width(7, w);
        pulse(MINT);
        lat = 0;
        while (echo !== 1'b1 && lat < 5000) begin @(negedge clk); lat++; end
        enable = 1'b0;
        wid = 0;
        while (echo === 1'b1 && wid < 5000) begin @(negedge clk); wid++; end
        checks++; if (wid !== w) begin errors++; $display("FAIL enable_drop_width got=%0d want=%0d", wid, w); end
        enable = 1'b1;
        count_busy(k);
    endtask

    task automatic test_back_to_back;
        int lat, wid, w, k, r0;
        bit bd;
        distance_cm = 9'd20;
        exp_width(20, w);
        pulse(MINT);
        lat = 0;
        while (echo !== 1'b1 && lat < 5000) begin @(negedge clk); lat++; end
        distance_cm = 9'd5;
        wid = 0;
        while (echo === 1'b1 && wid < 5000) begin
            @(negedge clk);
            wid++;
            if (wid == 10) trigger = 1'b1;
            if (wid == 20) trigger = 1'b0;
        end
        checks++; if (wid !== w) begin errors++; $display("FAIL retrig_width got=%0d want=%0d", wid, w); end
        count_busy(k);
        checks++; if (k !== HO) begin errors++; $display("FAIL retrig_holdoff got=%0d want=%0d", k, HO); end
        r0 = n_rise;
        repeat (100) @(negedge clk);
        checks++; if (n_rise !== r0) begin errors++; $display("FAIL retrig_no_second got=%0d want=0", n_rise - r0); end
        exp_width(5, w);
        pulse(MINT);
        measure(lat, wid, bd);
        checks++; if (wid !== w) begin errors++; $display("FAIL retrig_new_width got=%0d want=%0d", wid, w); end
        trigger = 1'b1;
        count_busy(k);
        repeat (20) @(negedge clk);
        r0 = n_rise;
        trigger = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (n_rise !== r0 || busy !== 1'b0) begin
            errors++; $display("FAIL held_trigger_ignored rises=%0d busy=%b want 0 0", n_rise - r0, busy);
        end
    endtask

    task automatic test_reset_mid_echo;
        int lat, wid, w, k, r0;
        bit bd;
        distance_cm = 9'd20;
        exp_width(20, w);
        pulse(MINT);
        lat = 0;
        while (echo !== 1'b1 && lat < 5000) begin @(negedge clk); lat++; end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (echo !== 1'b0) begin errors++; $display("FAIL rst_mid_echo got=%b want=0", echo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_lfsr = 16'hACE1;
        r0 = n_rise;
        repeat (10) @(negedge clk);
        checks++; if (n_rise !== r0) begin errors++; $display("FAIL rst_residual got=%0d want=0", n_rise - r0); end
        distance_cm = 9'd1;
        exp_width(1, w);
        pulse(MINT);
        measure(lat, wid, bd);
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rst_next_latency got=%0d want=%0d", lat, LAT); end
        checks++; if (wid !== w) begin errors++; $display("FAIL rst_next_width got=%0d want=%0d", wid, w); end
        count_busy(k);
    endtask

`ifdef ULTRASONIC_JITTER_EN
    task automatic test_jitter;
        int lat, wid, w, k;
        bit bd;
        distance_cm = 9'd10;
        for (int i = 0; i < 3; i++) begin
            exp_width(10, w);
            pulse(MINT);
            measure(lat, wid, bd);
            checks++; if (wid !== w) begin errors++; $display("FAIL jitter_width n=%0d got=%0d want=%0d", i, wid, w); end
            checks++; if (wid < 10 * TPC || wid > 10 * TPC + 63) begin
                errors++; $display("FAIL jitter_range n=%0d got=%0d want %0d..%0d", i, wid, 10 * TPC, 10 * TPC + 63);
            end
            count_busy(k);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_short_trigger();
        test_range();
        test_enable();
        test_back_to_back();
        test_reset_mid_echo();
`ifdef ULTRASONIC_JITTER_EN
        test_jitter();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
